output_port: RTL and testbench

- Output-side counterpart of the CPU input port.
- The CPU writes a data byte with a one-cycle `Write` strobe. The block buffers bytes in a small FIFO and presents them to an external consumer over a Valid/Ack handshake.
- Status flags let the CPU avoid overrunning the buffer.
- Sits between the CPU data bus / OUT-instruction decode and the external device pins.

---
 rtl/output_port_if.sv | 33 +++
 rtl/output_port.sv | 47 ++++
 tb/tb_output_port.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/output_port_if.sv
// output_port_if: CPU write side and device Valid/Ack side of the output port.
// Overflow/OvfClr exist only when OUTPUT_PORT_OVF_EN is defined.
interface output_port_if #(
    parameter int WIDTH_DATA_LENGTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH_DATA_LENGTH-1:0] Input;
    logic Write;
    logic Full;
    logic Empty;
    logic [$clog2(DEPTH+1)-1:0] Count;
    logic [WIDTH_DATA_LENGTH-1:0] Output;
    logic Valid;
    logic Ack;
`ifdef OUTPUT_PORT_OVF_EN
    logic Overflow;
    logic OvfClr;
`endif
    modport master (
        output Input, Write, Ack,
        input Full, Empty, Count, Output, Valid
`ifdef OUTPUT_PORT_OVF_EN
        , output OvfClr, input Overflow
`endif
    );
    modport slave (
        input Input, Write, Ack,
        output Full, Empty, Count, Output, Valid
`ifdef OUTPUT_PORT_OVF_EN
        , input OvfClr, output Overflow
`endif
    );
endinterface

// File: rtl/output_port.sv
// output_port: CPU-to-device byte FIFO with a Valid/Ack handshake.
// Define OUTPUT_PORT_OVF_EN to add the sticky Overflow flag and its OvfClr input.
module output_port #(
    parameter int WIDTH_DATA_LENGTH = 8,
    parameter int DEPTH = 4
) (
    input logic Clk,
    input logic Rst,
    output_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH_DATA_LENGTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic full, empty, pop, push;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign pop   = !empty && bus.Ack;
    // a same-cycle pop frees a slot, so a write into a full FIFO still lands
    assign push  = bus.Write && (!full || pop);
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge Clk)
        if (push) mem[wr_ptr] <= bus.Input;
    assign bus.Full   = full;
    assign bus.Empty  = empty;
    assign bus.Valid  = !empty;
    assign bus.Count  = count;
    assign bus.Output = empty ? '0 : mem[rd_ptr];
`ifdef OUTPUT_PORT_OVF_EN
    logic ovf;
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) ovf <= 1'b0;
        else if (bus.Write && full && !pop) ovf <= 1'b1;
        else if (bus.OvfClr) ovf <= 1'b0;
    assign bus.Overflow = ovf;
`endif
endmodule

// File: tb/tb_output_port.sv
// tb_output_port: directed test-plan sequences plus random traffic, checked every
// cycle against a queue-based model of the FIFO.
module tb_output_port;
    localparam int W = 8;
    localparam int D = 4;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] q[$];
    bit ovf_m = 1'b0;
    output_port_if #(.WIDTH_DATA_LENGTH(W), .DEPTH(D)) bus ();
    output_port #(.WIDTH_DATA_LENGTH(W), .DEPTH(D)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit wr, input logic [W-1:0] din, input bit ack, input bit clr);
        bus.Write = wr;
        bus.Input = din;
        bus.Ack = ack;
`ifdef OUTPUT_PORT_OVF_EN
        bus.OvfClr = clr;
`else
        if (clr) begin end
`endif
    endtask

    // one clock: drive inputs, advance the model at the edge, return at the next negedge
    task automatic cycle(input bit wr, input logic [W-1:0] din, input bit ack, input bit clr = 1'b0);
        bit pop, push;
        set_in(wr, din, ack, clr);
        @(posedge Clk);
        pop = q.size() > 0 && ack;
        push = wr && (q.size() < D || pop);
        if (wr && q.size() == D && !pop) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(din);
        @(negedge Clk);
    endtask

    task automatic expect_out(input string name, input int valid, input int out, input int cnt);
        chk({name, ".valid"}, int'(bus.Valid), valid);
        chk({name, ".output"}, int'(bus.Output), out);
        chk({name, ".count"}, int'(bus.Count), cnt);
    endtask

    // asynchronous reset pulse between edges; outputs must clear without a clock
    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, 1'b0);
        #2 Rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        #1;
        expect_out("reset", 0, 0, 0);
        chk("reset.empty", int'(bus.Empty), 1);
        chk("reset.full", int'(bus.Full), 0);
`ifdef OUTPUT_PORT_OVF_EN
        chk("reset.ovf", int'(bus.Overflow), 0);
`endif
        #1 Rst = 1'b1;
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            chk("m.count", int'(bus.Count), q.size());
            chk("m.valid", int'(bus.Valid), int'(q.size() > 0));
            chk("m.empty", int'(bus.Empty), int'(q.size() == 0));
            chk("m.full", int'(bus.Full), int'(q.size() == D));
            chk("m.output", int'(bus.Output), q.size() > 0 ? int'(q[0]) : 0);
`ifdef OUTPUT_PORT_OVF_EN
            chk("m.ovf", int'(bus.Overflow), int'(ovf_m));
`endif
        end
    end

    initial begin
        logic [W-1:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        set_in(1'b0, '0, 1'b0, 1'b0);
        #2;
        expect_out("init", 0, 0, 0);
        chk("init.empty", int'(bus.Empty), 1);
        #10 Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 8'h00, 1);
            expect_out("idle_ack", 0, 0, 0);
        end
        cycle(1, 8'hA5, 0);
        expect_out("single", 1, 'hA5, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 8'h00, 0);
            expect_out("hold", 1, 'hA5, 1);
        end
        cycle(0, 8'h00, 1);
        expect_out("single_pop", 0, 0, 0);
        chk("single_pop.empty", int'(bus.Empty), 1);
        for (int i = 0; i < 4; i++) cycle(1, fill[i], 0);
        chk("fill.full", int'(bus.Full), 1);
        cycle(1, 8'h55, 0);
        expect_out("drop", 1, 'h11, 4);
`ifdef OUTPUT_PORT_OVF_EN
        chk("drop.ovf", int'(bus.Overflow), 1);
        cycle(0, 8'h00, 0, 1);
        chk("ovf_clr", int'(bus.Overflow), 0);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("drain.order", int'(bus.Output), int'(fill[i]));
            cycle(0, 8'h00, 1);
        end
        chk("drain.empty", int'(bus.Empty), 1);
        for (int i = 0; i < 4; i++) cycle(1, fill[i], 0);
        cycle(1, 8'h55, 1);
        expect_out("simul", 1, 'h22, 4);
`ifdef OUTPUT_PORT_OVF_EN
        chk("simul.ovf", int'(bus.Overflow), 0);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("simul.order", int'(bus.Output), i == 3 ? 'h55 : int'(fill[i+1]));
            cycle(0, 8'h00, 1);
        end
        chk("simul.empty", int'(bus.Empty), 1);
        for (int i = 1; i <= 10; i++) begin
            cycle(1, W'(i), 1);
            expect_out("wrap", 1, i, 1);
        end
        cycle(0, 8'h00, 1);
        expect_out("wrap_end", 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, fill[i], 0);
        chk("pre_reset.count", int'(bus.Count), 3);
        do_reset();
        cycle(1, 8'h77, 0);
        expect_out("post_reset", 1, 'h77, 1);
        cycle(0, 8'h00, 1);
        expect_out("post_reset_pop", 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
